// File: rtl/buffer_read_sequencer.sv
// Streams a strided sequence of rows out of N_BUF parallel buffers into a
// 2-deep output FIFO with a valid/ready consumer interface.
module buffer_read_sequencer #(
   parameter int N_BUF       = 4,
   parameter int ADDR_RAM    = 8,
   parameter int WID_PE_BITS = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [ADDR_RAM-1:0]             base_addr,
   input  logic [ADDR_RAM-1:0]             stride,
   input  logic [ADDR_RAM-1:0]             len,
   input  logic [N_BUF-1:0]                buf_mask,
   output logic                            buf_mode,
   output logic [N_BUF-1:0]                m1_r_en,
   output logic [N_BUF*ADDR_RAM-1:0]       m1_r_addr,
   input  logic [N_BUF*WID_PE_BITS-1:0]    m1_output_bus,
   output logic [N_BUF*WID_PE_BITS-1:0]    out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            busy,
   output logic                            done,
   output logic [1:0]                      dbg_state
);

   localparam int ROW_W = N_BUF * WID_PE_BITS;

   // Handshake: a row moves to the consumer on every rising edge where
   // out_valid and out_ready are both high; out_valid never depends on out_ready.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_RAM-1:0]  addr_q, addr_d;
   logic [ADDR_RAM-1:0]  stride_q, stride_d;
   logic [ADDR_RAM-1:0]  remaining_q, remaining_d;
   logic [N_BUF-1:0]     mask_q, mask_d;
   logic                 inflight_q, inflight_d;
   logic [ROW_W-1:0]     mem_q [0:1];
   logic [ROW_W-1:0]     mem_d [0:1];
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [1:0]           cnt_q, cnt_d;

   logic [ROW_W-1:0]     lane_mask;
   logic [ROW_W-1:0]     masked_row;
   logic [1:0]           occ;
   logic [1:0]           occ_after;
   logic                 pop;
   logic                 pop_reg;
   logic                 bypass;
   logic                 push_reg;
   logic                 issue;

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < N_BUF; i++) begin
         lane_mask[i*WID_PE_BITS +: WID_PE_BITS] = {WID_PE_BITS{mask_q[i]}};
      end
   end

   assign masked_row = m1_output_bus & lane_mask;

   // The row on the bus counts as a FIFO occupant the cycle it arrives, so an
   // empty FIFO forwards it straight to the consumer without an extra cycle.
   always_comb begin
      occ       = cnt_q + {1'b0, inflight_q};
      out_valid = (occ != 2'd0);
      out_data  = '0;
      if (cnt_q != 2'd0) begin
         out_data = mem_q[rd_ptr_q];
      end else if (inflight_q) begin
         out_data = masked_row;
      end
      pop       = out_valid & out_ready;
      pop_reg   = pop & (cnt_q != 2'd0);
      bypass    = pop & (cnt_q == 2'd0);
      push_reg  = inflight_q & ~bypass;
      occ_after = occ - {1'b0, pop};
      issue     = (state_q == S_ISSUE) && (occ_after < 2'd2);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      stride_d    = stride_q;
      remaining_d = remaining_q;
      mask_d      = mask_q;
      inflight_d  = issue;
      mem_d[0]    = mem_q[0];
      mem_d[1]    = mem_q[1];
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q + {1'b0, push_reg} - {1'b0, pop_reg};

      if (push_reg) begin
         mem_d[wr_ptr_q] = masked_row;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_reg) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d      = base_addr;
               stride_d    = stride;
               remaining_d = len;
               mask_d      = buf_mask;
               state_d     = (len != '0) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               addr_d      = addr_q + stride_q;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == {{(ADDR_RAM-1){1'b0}}, 1'b1}) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (occ_after == 2'd0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         stride_q    <= '0;
         remaining_q <= '0;
         mask_q      <= '0;
         inflight_q  <= 1'b0;
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         remaining_q <= remaining_d;
         mask_q      <= mask_d;
         inflight_q  <= inflight_d;
         mem_q[0]    <= mem_d[0];
         mem_q[1]    <= mem_d[1];
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign m1_r_en   = issue ? mask_q : '0;
   assign m1_r_addr = issue ? {N_BUF{addr_q}} : '0;
   assign busy      = (state_q != S_IDLE);
   assign buf_mode  = busy;
   assign done      = (state_q == S_DONE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_buffer_read_sequencer.sv
// Bench for buffer_read_sequencer: buffer memory model, job-level expected
// queues built from base/stride/len/mask, per-cycle compare plus directed pins.
module tb_buffer_read_sequencer;
  localparam int N = 4;
  localparam int A = 8;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [A-1:0]   base_addr = '0;
  logic [A-1:0]   stride = '0;
  logic [A-1:0]   len = '0;
  logic [N-1:0]   buf_mask = '0;
  logic           buf_mode;
  logic [N-1:0]   m1_r_en;
  logic [N*A-1:0] m1_r_addr;
  logic [N*W-1:0] m1_output_bus = '0;
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           busy;
  logic           done;
  logic [1:0]     dbg_state;

  buffer_read_sequencer #(.N_BUF(N), .ADDR_RAM(A), .WID_PE_BITS(W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .len(len), .buf_mask(buf_mask), .buf_mode(buf_mode), .m1_r_en(m1_r_en),
    .m1_r_addr(m1_r_addr), .m1_output_bus(m1_output_bus), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- buffer memory model ----------------
  bit const_mode = 1'b0;

  function automatic logic [W-1:0] lane_val(input logic [A-1:0] a, input int lane);
    return W'(int'(a) * 3 + lane * 37 + 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (m1_r_en[i])
        m1_output_bus[i*W +: W] <= const_mode ? 8'h0A : lane_val(m1_r_addr[i*A +: A], i);
      else
        m1_output_bus[i*W +: W] <= W'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N*W-1:0] exp_q[$];
  logic [N*A-1:0] exp_addr_q[$];
  logic [N-1:0]   exp_mask;

  int en_cnt, valid_cnt, acc_cnt, done_cnt, busy_cnt, max_outst;
  int first_en_cyc, last_en_cyc, first_val_cyc, last_val_cyc, last_acc_cyc, done_cyc;
  logic [A-1:0]   addr_log [0:15];
  logic [N*W-1:0] first_row;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0; valid_cnt = 0; acc_cnt = 0; done_cnt = 0; busy_cnt = 0; max_outst = 0;
    first_en_cyc = -1; last_en_cyc = -1; first_val_cyc = -1; last_val_cyc = -1;
    last_acc_cyc = -1; done_cyc = -1; first_row = '0;
    for (int i = 0; i < 16; i++) addr_log[i] = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", {buf_mode, m1_r_en, m1_r_addr, out_data, out_valid, busy, done}, '0);
    end else begin
      chk("busy_vs_state", busy, (dbg_state != 2'd0));
      chk("buf_mode", buf_mode, busy);
      if (busy) busy_cnt++;
      if (m1_r_en != '0) begin
        chk("r_en_mask", m1_r_en, exp_mask);
        if (exp_addr_q.size() == 0) begin
          chk("extra_read", 1'b1, 1'b0);
        end else begin
          chk("r_addr", m1_r_addr, exp_addr_q.pop_front());
        end
        if (en_cnt < 16) addr_log[en_cnt] = m1_r_addr[A-1:0];
        if (first_en_cyc < 0) first_en_cyc = cyc;
        last_en_cyc = cyc;
        en_cnt++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_row", 1'b1, 1'b0);
        end else begin
          chk("row_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
        if (first_val_cyc < 0) begin
          first_val_cyc = cyc;
          first_row = out_data;
        end
        last_val_cyc = cyc;
        valid_cnt++;
        if (out_ready) begin
          acc_cnt++;
          last_acc_cyc = cyc;
        end
      end else begin
        chk("idle_data_zero", out_data, '0);
      end
      if (exp_mask != '0 && busy) begin
        if (en_cnt - acc_cnt > max_outst) max_outst = en_cnt - acc_cnt;
        chk("outstanding_le2", (en_cnt - acc_cnt) <= 2, 1'b1);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_all_rows", exp_q.size(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [A-1:0] b, input logic [A-1:0] s,
                           input logic [A-1:0] l, input logic [N-1:0] m);
    logic [A-1:0]   a;
    logic [N*W-1:0] row;
    clear_stats();
    exp_mask = m;
    for (int k = 0; k < int'(l); k++) begin
      a = A'(int'(b) + k * int'(s));
      row = '0;
      for (int i = 0; i < N; i++)
        if (m[i]) row[i*W +: W] = const_mode ? 8'h0A : lane_val(a, i);
      if (m != '0) exp_addr_q.push_back({N{a}});
      exp_q.push_back(row);
    end
    base_addr = b; stride = s; len = l; buf_mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_wait(input int budget, input int stall_lo, input int stall_hi,
                          input bit rnd, input int inj_at);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : !(t >= stall_lo && t < stall_hi);
      start = (t == inj_at);
      if (t == inj_at) begin
        base_addr = 8'hEE; stride = 8'd7; len = 8'd5; buf_mask = 4'b0011;
      end
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (done_cnt == 0) begin
      n_cmp++; n_err++;
      $display("FAIL job_timeout: no done within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_stats();
    exp_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, out_valid, m1_r_en}, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic stream: addresses 5..8 back-to-back, rows one cycle behind.
    start_job(8'd5, 8'd1, 8'd4, 4'hF);
    run_wait(50, -1, -1, 1'b0, -1);
    chk("t1_addr0", addr_log[0], 8'd5);
    chk("t1_addr1", addr_log[1], 8'd6);
    chk("t1_addr2", addr_log[2], 8'd7);
    chk("t1_addr3", addr_log[3], 8'd8);
    chk("t1_en_consecutive", last_en_cyc - first_en_cyc, 3);
    chk("t1_latency", first_val_cyc - first_en_cyc, 1);
    chk("t1_valid_run", last_val_cyc - first_val_cyc, 3);
    chk("t1_valid_cnt", valid_cnt, 4);
    chk("t1_done_after_acc", done_cyc - last_acc_cyc, 1);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_row0", first_row, {lane_val(8'd5, 3), lane_val(8'd5, 2), lane_val(8'd5, 1), lane_val(8'd5, 0)});

    // Address wrap.
    start_job(8'd254, 8'd3, 8'd3, 4'hF);
    run_wait(50, -1, -1, 1'b0, -1);
    chk("t2_addr0", addr_log[0], 8'd254);
    chk("t2_addr1", addr_log[1], 8'd1);
    chk("t2_addr2", addr_log[2], 8'd4);

    // Consumer stall mid-job, plus an ignored start.
    start_job(8'd10, 8'd2, 8'd8, 4'hF);
    run_wait(100, 3, 8, 1'b0, 5);
    chk("t3_acc_cnt", acc_cnt, 8);
    chk("t3_en_cnt", en_cnt, 8);
    chk("t3_max_outst", max_outst, 2);

    // Partial mask with constant bus data.
    const_mode = 1'b1;
    start_job(8'd40, 8'd1, 8'd2, 4'b0101);
    run_wait(50, -1, -1, 1'b0, -1);
    chk("t4_row_masked", first_row, 32'h000A000A);
    chk("t4_valid_cnt", valid_cnt, 2);
    const_mode = 1'b0;

    // Empty mask still delivers len zero rows.
    start_job(8'd60, 8'd4, 8'd3, 4'b0000);
    run_wait(50, -1, -1, 1'b0, -1);
    chk("t5_en_cnt", en_cnt, 0);
    chk("t5_valid_cnt", valid_cnt, 3);
    chk("t5_row_zero", first_row, '0);

    // Empty job; a start during its single busy cycle is ignored.
    start_job(8'd70, 8'd1, 8'd0, 4'hF);
    base_addr = 8'd90; len = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_busy_cycles", busy_cnt, 1);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_en_cnt", en_cnt, 0);
    chk("t6_valid_cnt", valid_cnt, 0);

    // Random consumer back-pressure.
    start_job(8'($urandom_range(0, 255)), 8'($urandom_range(1, 9)), 8'd6, 4'hF);
    run_wait(200, -1, -1, 1'b1, -1);
    chk("t7_acc_cnt", acc_cnt, 6);

    // Reset mid-job aborts without done; next job starts fresh.
    start_job(8'd20, 8'd1, 8'd8, 4'hF);
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int t = 0; t < 40 && acc_cnt < 3; t++) begin
      @(posedge clk); #1;
    end
    chk("t8_three_rows", acc_cnt, 3);
    rst = 1'b0;
    #1;
    chk("t8_async_clear", {buf_mode, m1_r_en, m1_r_addr, out_data, out_valid, busy, done}, '0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("t8_no_done", done_cnt, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    start_job(8'd100, 8'd1, 8'd2, 4'hF);
    run_wait(50, -1, -1, 1'b0, -1);
    chk("t8_new_base", addr_log[0], 8'd100);
    chk("t8_new_rows", acc_cnt, 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
